me_block_feeder: RTL and testbench

ME_BLOCK_FEEDER -- requirements
Module: me_block_feeder

---
 rtl/me_block_feeder.sv | 166 ++++++++++++++++
 tb/tb_me_block_feeder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_block_feeder.sv
// Streams one macroblock (256 current + 1024 reference pixels) into Me_engine RAMs, starts the search, returns the vector.
// Optional WAIT_DONE watchdog: define ME_FEEDER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | waiting for start
// LOAD_CUR  | packing 256 current pixels into 32 words
// LOAD_REF  | packing 1024 reference pixels into 128 words
// GO        | one-cycle go pulse, last ref write in flight
// WAIT_DONE | waiting for Me_engine done (or watchdog)
// RESULT    | holding mv_* until mv_ready
module me_block_feeder #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic [4:0]  address_write_cur,
  output logic [63:0] data_write_cur,
  output logic        write_enable_cur,
  output logic [6:0]  address_write_ref,
  output logic [63:0] data_write_ref,
  output logic        write_enable_ref,
  output logic        go,
  input  logic        done,
  input  logic [7:0]  m_i,
  input  logic [7:0]  m_j,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic [7:0]  mv_i,
  output logic [7:0]  mv_j,
  output logic        mv_err,
  output logic [15:0] block_count
);

  typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_REF, GO, WAIT_DONE, RESULT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  pix_cnt;
  logic [6:0]  word_cnt;
  logic [55:0] acc;
  logic        accept, word_end, cur_last, ref_last, timeout_hit;

  assign accept   = pix_valid & pix_ready;
  assign word_end = accept & (pix_cnt == 3'd7);
  assign cur_last = word_end & (state == LOAD_CUR) & (word_cnt == 7'd31);
  assign ref_last = word_end & (state == LOAD_REF) & (word_cnt == 7'd127);

`ifdef ME_FEEDER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr;

  // Loaded in GO so WAIT_DONE lasts exactly TIMEOUT_CYCLES cycles without done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if (state == GO) begin
      tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (state == WAIT_DONE && tmr != '0) begin
      tmr <= tmr - 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT_DONE) & ~done & (tmr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mv_err <= 1'b0;
    end else if (state == WAIT_DONE) begin
      if (done) mv_err <= 1'b0;
      else if (timeout_hit) mv_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mv_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    go        = 1'b0;
    mv_valid  = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = LOAD_CUR;
      LOAD_CUR: begin
        pix_ready = 1'b1;
        if (cur_last) state_nxt = LOAD_REF;
      end
      LOAD_REF: begin
        pix_ready = 1'b1;
        if (ref_last) state_nxt = GO;
      end
      GO: begin
        go        = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (done || timeout_hit) state_nxt = RESULT;
      RESULT: begin
        mv_valid = 1'b1;
        if (mv_ready) state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Pixels shift in from the top so pixel 0 ends in the LSB byte of the word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt           <= '0;
      word_cnt          <= '0;
      acc               <= '0;
      address_write_cur <= '0;
      data_write_cur    <= '0;
      write_enable_cur  <= 1'b0;
      address_write_ref <= '0;
      data_write_ref    <= '0;
      write_enable_ref  <= 1'b0;
      mv_i              <= '0;
      mv_j              <= '0;
      block_count       <= '0;
    end else begin
      write_enable_cur <= 1'b0;
      write_enable_ref <= 1'b0;
      if (state == IDLE && start) begin
        pix_cnt  <= '0;
        word_cnt <= '0;
      end
      if (accept) begin
        acc     <= {pix_data, acc[55:8]};
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (word_end) begin
        if (state == LOAD_CUR) begin
          data_write_cur    <= {pix_data, acc};
          address_write_cur <= word_cnt[4:0];
          write_enable_cur  <= 1'b1;
        end else begin
          data_write_ref    <= {pix_data, acc};
          address_write_ref <= word_cnt;
          write_enable_ref  <= 1'b1;
        end
        word_cnt <= cur_last ? 7'd0 : word_cnt + 1'b1;
      end
      if (state == WAIT_DONE) begin
        if (done) begin
          mv_i <= m_i;
          mv_j <= m_j;
        end else if (timeout_hit) begin
          mv_i <= '0;
          mv_j <= '0;
        end
      end
      if (mv_valid && mv_ready) block_count <= block_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_me_block_feeder.sv
// Randomized bench for me_block_feeder: expected RAM writes and results come from a pixel-array model.
module tb_me_block_feeder;
`ifdef ME_FEEDER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        reset, start, pix_valid, pix_ready;
  logic [7:0]  pix_data;
  logic [4:0]  address_write_cur;
  logic [63:0] data_write_cur;
  logic        write_enable_cur;
  logic [6:0]  address_write_ref;
  logic [63:0] data_write_ref;
  logic        write_enable_ref;
  logic        go, done;
  logic [7:0]  m_i, m_j;
  logic        mv_valid, mv_ready;
  logic [7:0]  mv_i, mv_j;
  logic        mv_err;
  logic [15:0] block_count;

  always #5 clk = ~clk;

  me_block_feeder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .address_write_cur(address_write_cur), .data_write_cur(data_write_cur), .write_enable_cur(write_enable_cur),
    .address_write_ref(address_write_ref), .data_write_ref(data_write_ref), .write_enable_ref(write_enable_ref),
    .go(go), .done(done), .m_i(m_i), .m_j(m_j),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_i(mv_i), .mv_j(mv_j), .mv_err(mv_err),
    .block_count(block_count)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  pix [0:1279];
  logic [63:0] cur_d[$];
  int          cur_a[$];
  logic [63:0] ref_d[$];
  int          ref_a[$];
  logic [7:0]  exp_i, exp_j;
  logic        exp_err;
  logic [15:0] exp_count = 16'd0;
  int          go_count = 0, ready_cycles = 0, ref_blk = 0, cyc = 0, go_cyc = 0, mv_cyc = -1;
  bit          prev_go = 1'b0, first_seen = 1'b0;
  logic [63:0] first_word;
  int          first_addr = -1, last_ref_addr = -1;
  logic [7:0]  last_mv_i, last_mv_j;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (write_enable_cur) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_word = data_write_cur;
          first_addr = int'(address_write_cur);
        end
        if (cur_d.size() == 0) check("cur_unexpected_write", 1, 0);
        else begin
          check("cur_addr", 64'(address_write_cur), 64'(cur_a.pop_front()));
          check("cur_data", data_write_cur, cur_d.pop_front());
        end
      end
      if (write_enable_ref) begin
        ref_blk++;
        last_ref_addr = int'(address_write_ref);
        if (ref_d.size() == 0) check("ref_unexpected_write", 1, 0);
        else begin
          check("ref_addr", 64'(address_write_ref), 64'(ref_a.pop_front()));
          check("ref_data", data_write_ref, ref_d.pop_front());
        end
      end
      check("we_exclusive", 64'(write_enable_cur & write_enable_ref), 0);
      if (go) begin
        check("go_after_all_ref", 64'(ref_blk), 128);
        check("go_single_pulse", 64'(prev_go), 0);
        go_count++;
        go_cyc = cyc;
      end
      prev_go = go;
      if (mv_valid) begin
        if (mv_cyc < 0) mv_cyc = cyc;
        check("mv_i", 64'(mv_i), 64'(exp_i));
        check("mv_j", 64'(mv_j), 64'(exp_j));
        check("mv_err", 64'(mv_err), 64'(exp_err));
        last_mv_i = mv_i;
        last_mv_j = mv_j;
      end
      check("block_count", 64'(block_count), 64'(exp_count));
      if (mv_valid && mv_ready) exp_count++;
      if (pix_ready) ready_cycles++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prepare(input bit fixed);
    logic [63:0] w;
    for (int i = 0; i < 1280; i++)
      pix[i] = fixed ? 8'((i < 256) ? i : (i - 256) % 256) : 8'($urandom);
    cur_d.delete(); cur_a.delete(); ref_d.delete(); ref_a.delete();
    for (int wd = 0; wd < 160; wd++) begin
      for (int k = 0; k < 8; k++) w[8*k +: 8] = pix[8*wd + k];
      if (wd < 32) begin cur_d.push_back(w); cur_a.push_back(wd); end
      else begin ref_d.push_back(w); ref_a.push_back(wd - 32); end
    end
    ref_blk = 0;
    ready_cycles = 0;
    mv_cyc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // pat 0: continuous, 1: every other cycle, 2: random gaps plus ignored done/start noise
  task automatic stream(input int pat, input int limit);
    int  idx = 0;
    int  n = 0;
    bit  tog = 1'b1;
    while (idx < limit && n < 20000) begin
      case (pat)
        0:       pix_valid = 1'b1;
        1:       pix_valid = tog;
        default: pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      tog = ~tog;
      pix_data = pix_valid ? pix[idx] : 8'($urandom);
      done  = (pat == 2) && ($urandom_range(0, 15) == 0);
      start = (pat == 2) && ($urandom_range(0, 15) == 0);
      m_i   = 8'($urandom);
      m_j   = 8'($urandom);
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      step();
      n++;
    end
    pix_valid = 1'b0;
    done = 1'b0;
    start = 1'b0;
    if (idx < limit) check("stream_timeout", 64'(idx), 64'(limit));
  endtask

  task automatic run_block(input int pat, input bit fixed, input int rdelay, input bit no_done);
    int go0, t;
    go0 = go_count;
    prepare(fixed);
    stream(pat, 1280);
    t = 0;
    while (go_count == go0 && t < 50) begin step(); t++; end
    check("go_seen", 64'(go_count - go0), 1);
    if (pat == 0) check("load_cycles_cont", 64'(ready_cycles), 1280);
    if (pat == 1) check("load_cycles_alt", 64'(ready_cycles), 2559);
    exp_i = fixed ? 8'h03 : 8'($urandom);
    exp_j = fixed ? 8'hFD : 8'($urandom);
    exp_err = 1'b0;
    if (no_done) begin
`ifdef ME_FEEDER_TIMEOUT_EN
      exp_i = 8'h00; exp_j = 8'h00; exp_err = 1'b1;
`else
      repeat (40) step();
      check("no_done_waits", 64'(mv_valid), 0);
`endif
    end else begin
      repeat ($urandom_range(0, 5)) step();
    end
`ifdef ME_FEEDER_TIMEOUT_EN
    if (!no_done) begin
`endif
      done = 1'b1; m_i = exp_i; m_j = exp_j;
      step();
      done = 1'b0; m_i = 8'($urandom); m_j = 8'($urandom);
`ifdef ME_FEEDER_TIMEOUT_EN
    end
`endif
    mv_ready = (rdelay == 0);
    t = 0;
    while (!mv_valid && t < TO + 50) begin step(); t++; end
    check("mv_valid_seen", 64'(mv_valid), 1);
`ifdef ME_FEEDER_TIMEOUT_EN
    if (no_done) check("timeout_latency", 64'(mv_cyc - go_cyc), 64'(TO + 1));
`endif
    for (int i = 0; i < rdelay; i++) begin
      start = 1'(i % 2);
      done = 1'b1; m_i = 8'($urandom); m_j = 8'($urandom);
      step();
    end
    start = 1'b0;
    done = 1'b0;
    mv_ready = 1'b1;
    if (rdelay != 0) step();
    else begin
      @(negedge clk);
      step();
    end
    mv_ready = 1'b0;
    check("mv_valid_drop", 64'(mv_valid), 0);
    check("cur_queue_empty", 64'(cur_d.size()), 0);
    check("ref_queue_empty", 64'(ref_d.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_ready"}, 64'(pix_ready), 0);
    check({tag, "_we_cur"}, 64'(write_enable_cur), 0);
    check({tag, "_we_ref"}, 64'(write_enable_ref), 0);
    check({tag, "_addr_cur"}, 64'(address_write_cur), 0);
    check({tag, "_addr_ref"}, 64'(address_write_ref), 0);
    check({tag, "_data_cur"}, data_write_cur, 0);
    check({tag, "_data_ref"}, data_write_ref, 0);
    check({tag, "_go"}, 64'(go), 0);
    check({tag, "_mv_valid"}, 64'(mv_valid), 0);
    check({tag, "_mv_i"}, 64'(mv_i), 0);
    check({tag, "_mv_j"}, 64'(mv_j), 0);
    check({tag, "_mv_err"}, 64'(mv_err), 0);
    check({tag, "_block_count"}, 64'(block_count), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
    done = 1'b0; m_i = 8'h00; m_j = 8'h00; mv_ready = 1'b0;
    exp_i = 8'h00; exp_j = 8'h00; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    step();

    run_block(0, 1'b1, 0, 1'b0);
    check("lit_word0", first_word, 64'h0706050403020100);
    check("lit_addr0", 64'(first_addr), 0);
    check("lit_last_ref_addr", 64'(last_ref_addr), 127);
    check("lit_mv_i", 64'(last_mv_i), 64'h03);
    check("lit_mv_j", 64'(last_mv_j), 64'hFD);
    check("lit_block_count", 64'(block_count), 1);

    run_block(1, 1'b1, 0, 1'b0);
    run_block(2, 1'b0, 10, 1'b0);

    // Abort mid reference load, then verify a clean reload from address 0.
    prepare(1'b0);
    stream(0, 356);
    #2 reset = 1'b1;
    #1 check_all_zero("midload_reset");
    exp_count = 16'd0;
    cur_d.delete(); cur_a.delete(); ref_d.delete(); ref_a.delete();
    first_seen = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    run_block(0, 1'b0, 2, 1'b0);
    check("reload_addr0", 64'(first_addr), 0);
    check("count_after_reset", 64'(block_count), 1);

    run_block(0, 1'b0, 0, 1'b1);
    run_block(2, 1'b0, 3, 1'b0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end
endmodule
